ntable_loader: RTL and testbench

NTABLE_LOADER -- requirements
Module: ntable_loader

---
 rtl/ntable_pkg.sv | 18 +
 rtl/ntable_loader.sv | 129 ++++++++++++
 tb/tb_ntable_loader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntable_pkg.sv
// Shared definitions for the nametable stream loader: header default,
// FSM state encoding and the nametable address geometry.
package ntable_pkg;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;
  localparam int         NT_AW       = 10;
  localparam int         GRID_W      = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_H,
    S_ADDR_L,
    S_LEN,
    S_DATA,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/ntable_loader.sv
// Byte-stream packet loader that writes nametable RAM, optionally only
// while the display is outside its visible area.
//
// state  | meaning
// IDLE   | hunting for the header byte, other bytes dropped
// ADDR_H | expecting upper address bits (byte[7:2] must be zero)
// ADDR_L | expecting lower 8 address bits
// LEN    | expecting byte count (0 means 256)
// DATA   | accepting payload into the one-entry holding register
// DRAIN  | last byte held, waiting for its RAM write
module ntable_loader
  import ntable_pkg::*;
#(
  parameter int         C_MEMW       = 8,
  parameter bit         C_BLANK_ONLY = 1'b1,
  parameter logic [7:0] C_HDR        = HDR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              visible,
  output logic [NT_AW-1:0]  addr_ntable,
  output logic [C_MEMW-1:0] wd_ntable,
  output logic              we_ntable,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t              state_q, state_d;
  logic                pending_q;
  logic [8:0]          remaining_q;
  logic [NT_AW-1:0]    addr_q;
  logic [C_MEMW-1:0]   wd_q;
  logic                done_q, err_q;
  logic                done_set, err_set;
  logic                wr_ok, xfer, rdy;

  assign wr_ok = ~visible | (C_BLANK_ONLY == 1'b0);

  // Outputs are gated by rst_n so nothing leaks out while reset is held.
  assign we_ntable   = rst_n & pending_q & wr_ok;
  assign in_ready    = rst_n & rdy;
  assign xfer        = in_valid & in_ready;
  assign busy        = rst_n & (state_q != S_IDLE);
  assign done        = rst_n & done_q;
  assign err         = rst_n & err_q;
  assign addr_ntable = addr_q;          // {cuad_fila, cuad_col}
  assign wd_ntable   = wd_q;

  always_comb begin
    state_d  = state_q;
    rdy      = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        rdy = 1'b1;
        if (xfer && in_data == C_HDR) state_d = S_ADDR_H;
      end
      S_ADDR_H: begin
        rdy = 1'b1;
        if (xfer) begin
          if (in_data[7:2] != 6'd0) begin
            state_d = S_IDLE;
            err_set = 1'b1;
          end else begin
            state_d = S_ADDR_L;
          end
        end
      end
      S_ADDR_L: begin
        rdy = 1'b1;
        if (xfer) state_d = S_LEN;
      end
      S_LEN: begin
        rdy = 1'b1;
        if (xfer) state_d = S_DATA;
      end
      S_DATA: begin
        // Refill in the same cycle the held byte drains to RAM.
        rdy = ~pending_q | wr_ok;
        if (xfer && remaining_q == 9'd1) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (we_ntable) begin
          state_d  = S_IDLE;
          done_set = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pending_q   <= 1'b0;
      remaining_q <= 9'd0;
      addr_q      <= '0;
      wd_q        <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_set;
      err_q   <= err_set;

      if (xfer && state_q == S_ADDR_H)      addr_q[9:8] <= in_data[1:0];
      else if (xfer && state_q == S_ADDR_L) addr_q[7:0] <= in_data;
      else if (we_ntable)                   addr_q      <= addr_q + 10'd1;

      if (xfer && state_q == S_LEN)
        remaining_q <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
      else if (xfer && state_q == S_DATA)
        remaining_q <= remaining_q - 9'd1;

      if (xfer && state_q == S_DATA) begin
        wd_q      <= C_MEMW'(in_data);
        pending_q <= 1'b1;
      end else if (we_ntable) begin
        pending_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ntable_loader.sv
// Scoreboard bench for ntable_loader: packets are expanded into expected
// RAM writes and done/err events; a negedge monitor checks them in order.
module tb_ntable_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       visible = 1'b0;
  logic [9:0] addr_ntable;
  logic [7:0] wd_ntable;
  logic       we_ntable, busy, done, err;

  ntable_loader #(.C_MEMW(8), .C_BLANK_ONLY(1'b1), .C_HDR(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .visible(visible), .addr_ntable(addr_ntable),
    .wd_ntable(wd_ntable), .we_ntable(we_ntable), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [17:0] wq[$];   // {addr, data}
  int          evq[$];  // 1 = done, 2 = err
  bit          capture = 0;
  int          cap_q[$];
  int          cap_done = -1;
  int          vis_mode = 0;  // 0 blank, 1 visible, 2 random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (vis_mode)
      0: visible = 1'b0;
      1: visible = 1'b1;
      default: visible = ($urandom_range(0, 2) == 0);
    endcase
  end

  always @(negedge clk) begin
    logic [17:0] e;
    int ev;
    cyc = cyc + 1;
    if (rst_n) begin
      if (we_ntable) begin
        check("blank_only_write", {31'd0, visible}, 0);
        check("write_expected", {31'd0, wq.size() != 0}, 1);
        if (wq.size() != 0) begin
          e = wq.pop_front();
          check("write_addr", {22'd0, addr_ntable}, {22'd0, e[17:8]});
          check("write_data", {24'd0, wd_ntable}, {24'd0, e[7:0]});
        end
        if (capture) cap_q.push_back(cyc);
      end
      if (done || err) check("done_err_exclusive", {31'd0, done & err}, 0);
      if (done) begin
        check("busy_low_at_done", {31'd0, busy}, 0);
        check("done_expected", {31'd0, evq.size() != 0}, 1);
        if (evq.size() != 0) begin
          ev = evq.pop_front();
          check("event_is_done", ev, 1);
        end
        if (capture) cap_done = cyc;
      end
      if (err) begin
        check("err_expected", {31'd0, evq.size() != 0}, 1);
        if (evq.size() != 0) begin
          ev = evq.pop_front();
          check("event_is_err", ev, 2);
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    in_data  = b;
    in_valid = 1'b1;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("handshake", {31'd0, ok}, 1);
  endtask

  // Reference model: a packet at base with count N writes base+i mod 1024.
  task automatic send_packet(input logic [9:0] base, input logic [7:0] len,
                             input int max_gap, input logic [7:0] first_data);
    int n;
    logic [7:0] d[$];
    n = (len == 8'd0) ? 256 : int'(len);
    for (int i = 0; i < n; i++) begin
      logic [7:0] v;
      v = (i == 0) ? first_data : 8'($urandom);
      d.push_back(v);
      wq.push_back({10'((int'(base) + i) % 1024), v});
    end
    evq.push_back(1);
    send_byte(8'hA5);
    send_byte({6'd0, base[9:8]});
    send_byte(base[7:0]);
    send_byte(len);
    foreach (d[i]) begin
      send_byte(d[i]);
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 4000 && !ok; n++) begin
      @(negedge clk);
      ok = (wq.size() == 0) && (evq.size() == 0) && !busy;
    end
    check("drain_complete", {31'd0, ok}, 1);
    idle(1);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    idle(2);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 0);
    check("rst_we", {31'd0, we_ntable}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_addr", {22'd0, addr_ntable}, 0);
    check("rst_wd", {24'd0, wd_ntable}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 1);
    check("post_rst_busy", {31'd0, busy}, 0);
    @(posedge clk); #1;

    // Back-to-back blanking writes and done timing
    capture = 1;
    wq.push_back({10'h000, 8'h11});
    wq.push_back({10'h001, 8'h22});
    wq.push_back({10'h002, 8'h33});
    evq.push_back(1);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    wait_idle();
    capture = 0;
    check("burst_write_count", cap_q.size(), 3);
    if (cap_q.size() == 3) begin
      check("burst_gap_1", cap_q[1] - cap_q[0], 1);
      check("burst_gap_2", cap_q[2] - cap_q[1], 1);
      check("done_after_last", cap_done - cap_q[2], 1);
    end

    // Stall while visible, then release
    vis_mode = 1;
    idle(2);
    wq.push_back({10'h100, 8'hAA});
    wq.push_back({10'h101, 8'hBB});
    evq.push_back(1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hAA);
    in_data = 8'hBB; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 0);
      check("stall_no_write", {31'd0, we_ntable}, 0);
      @(posedge clk); #1;
    end
    vis_mode = 0;
    send_byte(8'hBB);
    wait_idle();

    // Address wrap; data byte equal to header is plain data
    wq.push_back({10'h3FF, 8'h5A});
    wq.push_back({10'h000, 8'hA5});
    evq.push_back(1);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'hFF); send_byte(8'h02);
    send_byte(8'h5A); send_byte(8'hA5);
    wait_idle();

    // Junk byte ignored, bad ADDR_H rejected
    evq.push_back(2);
    send_byte(8'h12); send_byte(8'hA5); send_byte(8'h04);
    idle(3);
    @(negedge clk);
    check("reject_idle", {31'd0, busy}, 0);
    check("reject_ready", {31'd0, in_ready}, 1);
    wait_idle();

    // LEN=0 means 256 bytes
    send_packet(10'h000, 8'h00, 0, 8'h01);
    wait_idle();

    // Randomized packets, junk and rejects under random visibility
    vis_mode = 2;
    for (int p = 0; p < 40; p++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        send_byte(8'($urandom_range(0, 8'hA4)));
      end else if (kind == 1) begin
        evq.push_back(2);
        send_byte(8'hA5);
        send_byte(8'($urandom_range(4, 255)));
      end else begin
        logic [9:0] base;
        base = ($urandom_range(0, 3) == 0) ? 10'(1024 - $urandom_range(1, 4))
                                            : 10'($urandom);
        send_packet(base, 8'($urandom_range(1, 12)), 2, 8'($urandom));
      end
      idle($urandom_range(0, 2));
    end
    vis_mode = 0;
    wait_idle();

    // Reset mid-packet with a held byte
    vis_mode = 1;
    idle(2);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10); send_byte(8'h04);
    send_byte(8'hC1);
    in_data = 8'hC2; in_valid = 1'b1;
    idle(1);
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("midrst_we", {31'd0, we_ntable}, 0);
    check("midrst_in_ready", {31'd0, in_ready}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_done_err", {30'd0, done, err}, 0);
    @(posedge clk); #1;
    idle(1);
    rst_n = 1'b1;
    vis_mode = 0;
    @(negedge clk);
    check("midrst_addr", {22'd0, addr_ntable}, 0);
    check("midrst_busy_after", {31'd0, busy}, 0);
    check("midrst_ready_after", {31'd0, in_ready}, 1);
    idle(6);

    check("final_write_queue", wq.size(), 0);
    check("final_event_queue", evq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
